// File: rtl/dff_readback.sv
// Serial readback engine: snapshots a parallel word on start and shifts it out
// MSB-first over a valid/ready handshake, then pulses done for one cycle.
module dff_readback #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cap_in,
  output logic             sdo,
  output logic             sdo_valid,
  input  logic             sdo_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sdo_n, sdo_valid_n, busy_n, done_n;

  // Next state, datapath and output values; outputs are decoded from the
  // next state so they land in registers on the same edge as the state.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;

    case (state)
      IDLE: begin
        if (start) begin
          sreg_n  = cap_in;
          cnt_n   = CW'(WIDTH - 1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (sdo_ready) begin
          if (cnt == '0) begin
            state_n = DONE;
          end else begin
            sreg_n = {sreg[WIDTH-2:0], 1'b0};
            cnt_n  = cnt - CW'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    sdo_valid_n = (state_n == SHIFT);
    sdo_n       = sdo_valid_n & sreg_n[WIDTH-1];
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      sdo       <= sdo_n;
      sdo_valid <= sdo_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_dff_readback.sv
// Bench for dff_readback: WIDTH=8 and WIDTH=2 instances sharing control inputs,
// directed vector table, hand-written corner sequences and a random run vs a model.
module tb_dff_readback;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] cap8 = 8'h00;
  logic [1:0] cap2 = 2'b00;

  logic sdo8, valid8, busy8, done8;
  logic sdo2, valid2, busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dff_readback #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .cap_in(cap8),
    .sdo(sdo8), .sdo_valid(valid8), .sdo_ready(ready),
    .busy(busy8), .done(done8)
  );

  dff_readback #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .cap_in(cap2),
    .sdo(sdo2), .sdo_valid(valid2), .sdo_ready(ready),
    .busy(busy2), .done(done2)
  );

  // Reference model: captured word plus number of bits still to deliver
  int unsigned m_w[2]    = '{8, 2};
  int unsigned m_left[2] = '{0, 0};
  logic [31:0] m_word[2] = '{32'd0, 32'd0};
  bit          m_done[2] = '{1'b0, 1'b0};

  typedef struct {
    logic       rst, start, ready;
    logic [7:0] cap;
    logic       sdo, valid, busy, done;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_left[i] = 0;
        m_done[i] = 1'b0;
      end else if (m_done[i]) begin
        m_done[i] = 1'b0;
      end else if (m_left[i] > 0) begin
        if (ready) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) m_done[i] = 1'b1;
        end
      end else if (start) begin
        m_word[i] = (i == 0) ? 32'(cap8) : 32'(cap2);
        m_left[i] = m_w[i];
      end
    end
  endtask

  function automatic logic exp_sdo(input int i);
    return (m_left[i] > 0) ? m_word[i][m_left[i]-1] : 1'b0;
  endfunction

  task automatic check_model();
    check("w8.sdo",   32'(sdo8),   32'(exp_sdo(0)));
    check("w8.valid", 32'(valid8), 32'(m_left[0] > 0));
    check("w8.busy",  32'(busy8),  32'(m_left[0] > 0 || m_done[0]));
    check("w8.done",  32'(done8),  32'(m_done[0]));
    check("w2.sdo",   32'(sdo2),   32'(exp_sdo(1)));
    check("w2.valid", 32'(valid2), 32'(m_left[1] > 0));
    check("w2.busy",  32'(busy2),  32'(m_left[1] > 0 || m_done[1]));
    check("w2.done",  32'(done2),  32'(m_done[1]));
  endtask

  // One clock: advance model on the edge, sample DUT 1 time unit later
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic add(input logic r, input logic s, input logic rd, input logic [7:0] c,
                     input logic e_sdo, input logic e_v, input logic e_b, input logic e_d);
    vec_t v;
    v.rst = r; v.start = s; v.ready = rd; v.cap = c;
    v.sdo = e_sdo; v.valid = e_v; v.busy = e_b; v.done = e_d;
    tbl.push_back(v);
  endtask

  initial begin
    logic [15:0] bits;
    int          nbits;
    int          cap_cycle[2];
    int          ncap;
    logic        prev_valid;

    // Basic 0xA5 with cap_in change and start during SHIFT/DONE ignored
    add(0,1,1,8'hA5, 1,1,1,0);
    add(0,0,1,8'hFF, 0,1,1,0);
    add(0,1,1,8'hFF, 1,1,1,0);
    add(0,0,1,8'h00, 0,1,1,0);
    add(0,0,1,8'h00, 0,1,1,0);
    add(0,0,1,8'h00, 1,1,1,0);
    add(0,0,1,8'h00, 0,1,1,0);
    add(0,0,1,8'h00, 1,1,1,0);
    add(0,0,1,8'h00, 0,0,1,1);
    add(0,1,1,8'h00, 0,0,0,0);
    add(0,0,1,8'h00, 0,0,0,0);
    // Backpressure 0x3C, three stalled cycles after the 2nd bit
    add(0,1,1,8'h3C, 0,1,1,0);
    add(0,0,1,8'h00, 0,1,1,0);
    add(0,0,1,8'h00, 1,1,1,0);
    add(0,0,0,8'h00, 1,1,1,0);
    add(0,0,0,8'h00, 1,1,1,0);
    add(0,0,0,8'h00, 1,1,1,0);
    add(0,0,1,8'h00, 1,1,1,0);
    add(0,0,1,8'h00, 1,1,1,0);
    add(0,0,1,8'h00, 1,1,1,0);
    add(0,0,1,8'h00, 0,1,1,0);
    add(0,0,1,8'h00, 0,1,1,0);
    add(0,0,1,8'h00, 0,0,1,1);
    add(0,0,1,8'h00, 0,0,0,0);
    // Reset after 4 bits, then 0x81
    add(0,1,1,8'hA5, 1,1,1,0);
    add(0,0,1,8'h00, 0,1,1,0);
    add(0,0,1,8'h00, 1,1,1,0);
    add(0,0,1,8'h00, 0,1,1,0);
    add(0,0,1,8'h00, 0,1,1,0);
    add(1,1,1,8'h00, 0,0,0,0);
    add(0,1,1,8'h81, 1,1,1,0);
    for (int k = 0; k < 6; k++) add(0,0,1,8'h00, 0,1,1,0);
    add(0,0,1,8'h00, 1,1,1,0);
    add(0,0,1,8'h00, 0,0,1,1);
    add(0,0,1,8'h00, 0,0,0,0);

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    check("rst.busy8", 32'(busy8), 32'd0);
    check("rst.sdo2",  32'(sdo2),  32'd0);
    rst = 1'b0;
    cyc();

    // Directed table
    foreach (tbl[i]) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      ready = tbl[i].ready;
      cap8  = tbl[i].cap;
      cap2  = tbl[i].cap[1:0];
      cyc();
      check($sformatf("tbl%0d.sdo", i),   32'(sdo8),   32'(tbl[i].sdo));
      check($sformatf("tbl%0d.valid", i), 32'(valid8), 32'(tbl[i].valid));
      check($sformatf("tbl%0d.busy", i),  32'(busy8),  32'(tbl[i].busy));
      check($sformatf("tbl%0d.done", i),  32'(done8),  32'(tbl[i].done));
    end
    rst = 1'b0; start = 1'b0; ready = 1'b1;
    for (int k = 0; k < 12; k++) cyc();

    // Back-to-back with start held high: 0xF0 then 0x0F
    start = 1'b1; cap8 = 8'hF0;
    bits = '0; nbits = 0; ncap = 0; prev_valid = 1'b0;
    cap_cycle[0] = 0; cap_cycle[1] = 0;
    for (int c = 0; c < 40 && nbits < 16; c++) begin
      cyc();
      if (c == 0) cap8 = 8'h0F;
      if (valid8 && !prev_valid && ncap < 2) begin
        cap_cycle[ncap] = c;
        ncap++;
      end
      if (valid8) begin
        bits = {bits[14:0], sdo8};
        nbits++;
      end
      prev_valid = valid8;
    end
    check("b2b.nbits",  32'(nbits), 32'd16);
    check("b2b.bits",   32'(bits), 32'hF00F);
    check("b2b.period", 32'(cap_cycle[1] - cap_cycle[0]), 32'd10);
    start = 1'b0;
    for (int k = 0; k < 12; k++) cyc();

    // Minimum width: 2'b10
    start = 1'b1; cap2 = 2'b10; cap8 = 8'h00;
    cyc();
    start = 1'b0;
    check("w2.e0.sdo",   32'(sdo2),   32'd1);
    check("w2.e0.valid", 32'(valid2), 32'd1);
    cyc();
    check("w2.e1.sdo",   32'(sdo2),   32'd0);
    check("w2.e1.valid", 32'(valid2), 32'd1);
    cyc();
    check("w2.e2.done",  32'(done2),  32'd1);
    check("w2.e2.busy",  32'(busy2),  32'd1);
    check("w2.e2.valid", 32'(valid2), 32'd0);
    cyc();
    check("w2.e3.done",  32'(done2),  32'd0);
    check("w2.e3.busy",  32'(busy2),  32'd0);
    for (int k = 0; k < 12; k++) cyc();

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 3) != 0);
      cap8  = 8'($urandom);
      cap2  = 2'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
